mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the pipelined core. Sits between the EX/MEM pipeline register and an external data memory that uses a req/gnt/rvalid handshake.
- Holds the pipeline with `stall` while an access is outstanding, and injects bubbles into MEM/WB until the access completes.
- Generates byte enables and store-lane alignment, and sign- or zero-extends load data before it reaches MEM/WB.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles spent in REQ+WAIT before the access is aborted with `bus_err`.
- CNT_W, 8: timeout counter width; TIMEOUT_CYC must be < 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- mem_read_in  in  1  MEM-stage instruction is a load.
- mem_write_in  in  1  MEM-stage instruction is a store. Both read and write high at once is illegal; read wins.
- funct3_in  in  3  RV funct3. Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Stores: 000–011.
- addr_in  in  64  byte address (ALU result).
- wdata_in  in  64  store data, right-aligned.
- stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
- wb_bubble  out  1  forces MEM/WB to capture a bubble (regWrite=0).
- rdata_out  out  64  extended load data; valid in DONE.
- misalign_err  out  1  one-cycle pulse on a misaligned access.
- bus_err  out  1  one-cycle pulse on a timeout abort.
- mem_req  out  1  request valid; registered.
- mem_we  out  1  write request.
- mem_addr  out  64  doubleword-aligned address (addr_in & ~7).
- mem_be  out  8  byte enables.
- mem_wdata  out  64  store data shifted to its byte lanes.
- mem_gnt  in  1  request accepted this cycle; valid only while mem_req=1.
- mem_rvalid  in  1  read data valid; earliest one cycle after gnt.
- mem_rdata  in  64  read doubleword.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset (any cycle, including mid-access) → IDLE.
- Reset values: all outputs 0. A response that arrives after reset is ignored.
- `access = mem_read_in | mem_write_in`.
- Combinational outputs: `stall = access & (state != DONE)`; `wb_bubble = stall`.
- Size: funct3[1:0] selects 1/2/4/8 bytes.
  - Misaligned when `addr_in[2:0] mod size != 0`.
- IDLE, access, misaligned: pulse `misalign_err`, issue no memory request, go DONE with `rdata_out = 0`.
- IDLE, access, aligned:
  - Latch `mem_addr`, `mem_we = mem_write_in`, `mem_be = ((1<<size)-1) << addr_in[2:0]`, `mem_wdata = wdata_in << (8*addr_in[2:0])`.
  - Latch load funct3 and offset.
  - Set `mem_req = 1`, clear counter, go REQ.
- REQ: `mem_req` holds at 1 and all request fields stay stable until gnt.
  - On gnt: `mem_req` → 0 next edge. Store → DONE; load → WAIT.
- WAIT: on rvalid, capture `rdata_out = ext(mem_rdata >> (8*offset))`, go DONE.
  - Extension: LB/LH/LW sign-extend from bit 7/15/31; LBU/LHU/LWU zero-extend; LD passes through.
- Timeout: counter increments each cycle in REQ or WAIT.
  - When counter == TIMEOUT_CYC: `mem_req` → 0, pulse `bus_err`, `rdata_out = 0`, go DONE.
  - gnt or rvalid in that same cycle takes priority over the timeout.
- DONE: `stall = 0`, so the pipeline advances and MEM/WB captures `rdata_out`. Next state is IDLE unconditionally.
  - A new access presented in the following cycle starts from IDLE.
  - Error pulses (`bus_err`, `misalign_err`) are asserted in the DONE cycle.
- Minimum latency with gnt in the first REQ cycle and rvalid one cycle later:
  - Load: 3 stall cycles, data in cycle 4.
  - Store: 2 stall cycles.
- Back-to-back accesses each take the full sequence; there is no pipelining of requests.
- `rdata_out` holds its value outside DONE and is only meaningful in DONE.

Test Plan:
- LD at 0x1000, gnt immediately, rvalid next cycle with 0x1122334455667788 → `stall` high 3 cycles, `mem_be = 0xFF`, `rdata_out = 0x1122334455667788` in DONE.
- LB at 0x1003 with `mem_rdata = 0x00000000_80000000` → `mem_addr = 0x1000`, `mem_be = 0x08`, `rdata_out = 0xFFFFFFFFFFFFFF80`. Same access as LBU → `0x80`.
- SH at 0x2006 with `wdata_in = 0xABCD`, gnt delayed 4 cycles → `mem_req` held 5 cycles with stable fields, `mem_be = 0xC0`, `mem_wdata = 0xABCD << 48`, `stall` 6 cycles.
- LW at 0x3002 → `misalign_err` pulses, `mem_req` never asserted, 1 stall cycle.
- Load with gnt but no rvalid, TIMEOUT_CYC = 4 → `bus_err` pulses after 4 counted cycles, `rdata_out = 0`, pipeline released. A late rvalid is ignored.
- `reset` asserted in WAIT → IDLE and `mem_req = 0` next cycle, `stall = 0` once access inputs clear. A subsequent SD completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/response bus used by the MEM-stage access controller.
// The controller drives the request side (master); the memory answers with gnt/rvalid/rdata.
interface mem_access_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [7:0]  mem_be;
   logic [63:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: holds the pipeline while an access is outstanding,
// aligns store lanes, extends load data and aborts accesses that never complete.
//
// state | meaning
// IDLE  | no access in flight; decode and launch a new access
// REQ   | mem_req held with stable fields until the memory grants
// WAIT  | load granted, waiting for rvalid
// DONE  | one cycle: pipeline released, rdata_out / error pulses valid
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mem_read_in,
   input  logic               mem_write_in,
   input  logic [2:0]         funct3_in,
   input  logic [63:0]        addr_in,
   input  logic [63:0]        wdata_in,
   output logic               stall,
   output logic               wb_bubble,
   output logic [63:0]        rdata_out,
   output logic               misalign_err,
   output logic               bus_err,
   mem_access_ctrl_if.master  mem
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = TIMEOUT_CYC[CNT_W-1:0];

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [63:0]       addr_q, addr_d;
   logic [7:0]        be_q, be_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [2:0]        f3_q, f3_d;
   logic [2:0]        off_q, off_d;
   logic [63:0]       rdata_q, rdata_d;
   logic              mis_q, mis_d;
   logic              berr_q, berr_d;

   logic              access;
   logic [2:0]        off_in;
   logic [2:0]        size_mask;
   logic [7:0]        be_base;
   logic              misaligned;
   logic              timeout;
   logic [63:0]       rshift;
   logic [63:0]       rdata_ext;

   assign access     = mem_read_in | mem_write_in;
   assign off_in     = addr_in[2:0];
   assign misaligned = |(off_in & size_mask);
   assign timeout    = (cnt_q == TIMEOUT_CNT);

   always_comb begin
      size_mask = 3'b000;
      be_base   = 8'h01;
      case (funct3_in[1:0])
         2'b00: begin size_mask = 3'b000; be_base = 8'h01; end
         2'b01: begin size_mask = 3'b001; be_base = 8'h03; end
         2'b10: begin size_mask = 3'b011; be_base = 8'h0F; end
         default: begin size_mask = 3'b111; be_base = 8'hFF; end
      endcase
   end

   always_comb begin
      rshift    = mem.mem_rdata >> {off_q, 3'b000};
      rdata_ext = rshift;
      case (f3_q)
         3'b000: rdata_ext = {{56{rshift[7]}},  rshift[7:0]};
         3'b001: rdata_ext = {{48{rshift[15]}}, rshift[15:0]};
         3'b010: rdata_ext = {{32{rshift[31]}}, rshift[31:0]};
         3'b100: rdata_ext = {56'd0, rshift[7:0]};
         3'b101: rdata_ext = {48'd0, rshift[15:0]};
         3'b110: rdata_ext = {32'd0, rshift[31:0]};
         default: rdata_ext = rshift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rdata_d = rdata_q;
      mis_d   = 1'b0;
      berr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               if (misaligned) begin
                  mis_d   = 1'b1;
                  rdata_d = '0;
                  state_d = S_DONE;
               end else begin
                  addr_d  = {addr_in[63:3], 3'b000};
                  we_d    = mem_write_in & ~mem_read_in;
                  be_d    = be_base << off_in;
                  wdata_d = wdata_in << {off_in, 3'b000};
                  f3_d    = funct3_in;
                  off_d   = off_in;
                  req_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ, S_WAIT: begin
            // Saturate so a grant landing on the last cycle still leaves WAIT bounded.
            cnt_d = timeout ? cnt_q : cnt_q + CNT_W'(1);
            if (state_q == S_REQ && mem.mem_gnt) begin
               req_d   = 1'b0;
               state_d = we_q ? S_DONE : S_WAIT;
            end else if (state_q == S_WAIT && mem.mem_rvalid) begin
               rdata_d = rdata_ext;
               state_d = S_DONE;
            end else if (timeout) begin
               req_d   = 1'b0;
               berr_d  = 1'b1;
               rdata_d = '0;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall     = access & (state_q != S_DONE);
      wb_bubble = stall;
   end

   assign rdata_out     = rdata_q;
   assign misalign_err  = mis_q;
   assign bus_err       = berr_q;
   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_be    = be_q;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized accesses
// scored against a cycle-count / data model derived from the access rules.
module tb_mem_access_ctrl;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_in, mem_write_in;
   logic [2:0]  funct3_in;
   logic [63:0] addr_in, wdata_in;
   logic        stall, wb_bubble, misalign_err, bus_err;
   logic [63:0] rdata_out;

   int tests_run = 0;
   int fails = 0;

   mem_access_ctrl_if bus();

   mem_access_ctrl #(.TIMEOUT_CYC(T), .CNT_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_read_in  (mem_read_in),
      .mem_write_in (mem_write_in),
      .funct3_in    (funct3_in),
      .addr_in      (addr_in),
      .wdata_in     (wdata_in),
      .stall        (stall),
      .wb_bubble    (wb_bubble),
      .rdata_out    (rdata_out),
      .misalign_err (misalign_err),
      .bus_err      (bus_err),
      .mem          (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          stall_cyc;
      int          req_cyc;
      int          mis_cnt;
      int          berr_cnt;
      bit          fields_ok;
      bit          bubble_ok;
      bit          done;
      bit          req_after;
      logic [63:0] rdata;
      logic [63:0] rdata_after;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic        we;
   } obs_t;

   function automatic obs_t blank();
      obs_t o;
      o.stall_cyc = 0; o.req_cyc = 0; o.mis_cnt = 0; o.berr_cnt = 0;
      o.fields_ok = 1; o.bubble_ok = 1; o.done = 0; o.req_after = 0;
      o.rdata = '0; o.rdata_after = '0; o.addr = '0; o.wdata = '0; o.be = '0; o.we = 0;
      return o;
   endfunction

   // Reference model: cycles counted from the first cycle the access is presented.
   function automatic obs_t model(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [63:0] addr, input logic [63:0] wd,
                                  input int g, input int r, input logic [63:0] rdv);
      obs_t e = blank();
      int size = 1 << f3[1:0];
      int off  = int'(addr[2:0]);
      int bem;
      logic [63:0] v, m;
      if (off % size != 0) begin
         e.stall_cyc = 1; e.mis_cnt = 1;
         return e;
      end
      bem     = ((1 << size) - 1) << off;
      e.be    = bem[7:0];
      e.addr  = addr & ~64'h7;
      e.wdata = wd << (8 * off);
      e.we    = wr && !rd;
      if (!rd) begin
         if (g <= T) begin e.stall_cyc = g + 2; e.req_cyc = g + 1; end
         else begin e.stall_cyc = T + 2; e.req_cyc = T + 1; e.berr_cnt = 1; end
      end else if (g > T) begin
         e.stall_cyc = T + 2; e.req_cyc = T + 1; e.berr_cnt = 1;
      end else if (g + r <= T) begin
         e.stall_cyc = g + r + 2; e.req_cyc = g + 1;
         v = rdv >> (8 * off);
         if (size < 8) begin
            m = (64'd1 << (8 * size)) - 64'd1;
            v = v & m;
            if (!f3[2] && v[8*size-1]) v = v | ~m;
         end
         e.rdata = v;
      end else begin
         e.stall_cyc = T + 2; e.req_cyc = g + 1; e.berr_cnt = 1;
      end
      return e;
   endfunction

   // Presents one access, acts as the memory (gnt after g waiting REQ cycles, rvalid r cycles
   // after gnt) and records what the DUT did. npost idle cycles follow; late_rv drives a stray rvalid.
   task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] wd,
                             input int g, input int r, input logic [63:0] rdv,
                             input int npost, input bit late_rv, output obs_t o);
      int cyc = 0;
      int gnt_cyc = -1;
      o = blank();
      while (!o.done && cyc < 60) begin
         @(negedge clk);
         mem_read_in = rd; mem_write_in = wr; funct3_in = f3; addr_in = addr; wdata_in = wd;
         bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
         bus.mem_rdata = {$urandom, $urandom};
         if (bus.mem_req) begin
            o.req_cyc++;
            if (o.req_cyc == 1) begin
               o.addr = bus.mem_addr; o.be = bus.mem_be; o.wdata = bus.mem_wdata; o.we = bus.mem_we;
            end else if (bus.mem_addr !== o.addr || bus.mem_be !== o.be ||
                         bus.mem_wdata !== o.wdata || bus.mem_we !== o.we) begin
               o.fields_ok = 0;
            end
            if (o.req_cyc == g + 1) begin
               bus.mem_gnt = 1'b1; gnt_cyc = cyc;
            end
         end
         if (gnt_cyc >= 0 && cyc == gnt_cyc + r) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = rdv;
         end
         #1;
         if (wb_bubble !== stall) o.bubble_ok = 0;
         if (stall) o.stall_cyc++;
         else begin o.done = 1; o.rdata = rdata_out; end
         o.mis_cnt  += int'(misalign_err);
         o.berr_cnt += int'(bus_err);
         cyc++;
      end
      for (int p = 0; p < npost; p++) begin
         @(negedge clk);
         mem_read_in = 0; mem_write_in = 0; bus.mem_gnt = 1'b0;
         bus.mem_rvalid = (late_rv && p == 0);
         bus.mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
         #1;
         o.mis_cnt  += int'(misalign_err);
         o.berr_cnt += int'(bus_err);
         if (bus.mem_req || stall) o.req_after = 1;
         o.rdata_after = rdata_out;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mem_read_in = 0; mem_write_in = 0; funct3_in = 0; addr_in = 0; wdata_in = 0;
      bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
      repeat (3) @(negedge clk);
      #1;
      tests_run++;
      if ({stall, wb_bubble, misalign_err, bus_err, bus.mem_req, bus.mem_we} !== 6'b0 ||
          rdata_out !== 64'd0 || bus.mem_addr !== 64'd0 || bus.mem_be !== 8'd0 ||
          bus.mem_wdata !== 64'd0) begin
         fails++;
         $display("FAIL reset_outputs: stall=%b req=%b rdata=%h addr=%h be=%h required all zero",
                  stall, bus.mem_req, rdata_out, bus.mem_addr, bus.mem_be);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_ld();
      obs_t o;
      run_access(1, 0, 3'b011, 64'h1000, 64'd0, 0, 1, 64'h1122334455667788, 2, 0, o);
      tests_run++;
      if (o.stall_cyc != 3) begin fails++; $display("FAIL ld_stall: got %0d required 3", o.stall_cyc); end
      tests_run++;
      if (o.be !== 8'hFF || o.addr !== 64'h1000 || o.we !== 1'b0) begin
         fails++; $display("FAIL ld_fields: be=%h addr=%h we=%b required FF 1000 0", o.be, o.addr, o.we);
      end
      tests_run++;
      if (o.rdata !== 64'h1122334455667788) begin
         fails++; $display("FAIL ld_rdata: got %h required 1122334455667788", o.rdata);
      end
      tests_run++;
      if (!o.bubble_ok) begin fails++; $display("FAIL ld_bubble: wb_bubble differs from stall, required equal"); end
   endtask

   task automatic test_lb();
      obs_t o;
      run_access(1, 0, 3'b000, 64'h1003, 64'd0, 0, 1, 64'h0000000080000000, 1, 0, o);
      tests_run++;
      if (o.addr !== 64'h1000 || o.be !== 8'h08) begin
         fails++; $display("FAIL lb_fields: addr=%h be=%h required 1000 08", o.addr, o.be);
      end
      tests_run++;
      if (o.rdata !== 64'hFFFFFFFFFFFFFF80) begin
         fails++; $display("FAIL lb_rdata: got %h required FFFFFFFFFFFFFF80", o.rdata);
      end
      run_access(1, 0, 3'b100, 64'h1003, 64'd0, 0, 1, 64'h0000000080000000, 1, 0, o);
      tests_run++;
      if (o.rdata !== 64'h80) begin fails++; $display("FAIL lbu_rdata: got %h required 80", o.rdata); end
   endtask

   task automatic test_sh();
      obs_t o;
      run_access(0, 1, 3'b001, 64'h2006, 64'hABCD, 4, 1, 64'd0, 1, 0, o);
      tests_run++;
      if (o.req_cyc != 5 || !o.fields_ok) begin
         fails++; $display("FAIL sh_req_hold: req_cycles=%0d stable=%0d required 5 1", o.req_cyc, o.fields_ok);
      end
      tests_run++;
      if (o.be !== 8'hC0 || o.wdata !== 64'hABCD000000000000 || o.we !== 1'b1) begin
         fails++; $display("FAIL sh_fields: be=%h wdata=%h we=%b required C0 ABCD000000000000 1",
                           o.be, o.wdata, o.we);
      end
      tests_run++;
      if (o.stall_cyc != 6) begin fails++; $display("FAIL sh_stall: got %0d required 6", o.stall_cyc); end
   endtask

   task automatic test_misalign();
      obs_t o;
      run_access(1, 0, 3'b010, 64'h3002, 64'd0, 0, 1, 64'h1234, 1, 0, o);
      tests_run++;
      if (o.mis_cnt != 1 || o.berr_cnt != 0) begin
         fails++; $display("FAIL misalign_pulse: mis=%0d berr=%0d required 1 0", o.mis_cnt, o.berr_cnt);
      end
      tests_run++;
      if (o.req_cyc != 0 || o.stall_cyc != 1 || o.rdata !== 64'd0) begin
         fails++; $display("FAIL misalign_seq: req=%0d stall=%0d rdata=%h required 0 1 0",
                           o.req_cyc, o.stall_cyc, o.rdata);
      end
   endtask

   task automatic test_timeout();
      obs_t o;
      run_access(1, 0, 3'b011, 64'h4000, 64'd0, 0, 1000, 64'd0, 2, 1, o);
      tests_run++;
      if (o.berr_cnt != 1 || o.stall_cyc != T + 2 || o.rdata !== 64'd0) begin
         fails++; $display("FAIL timeout_load: berr=%0d stall=%0d rdata=%h required 1 %0d 0",
                           o.berr_cnt, o.stall_cyc, o.rdata, T + 2);
      end
      tests_run++;
      if (o.rdata_after !== 64'd0 || o.req_after) begin
         fails++; $display("FAIL timeout_late_rvalid: rdata=%h busy=%0d required 0 0", o.rdata_after, o.req_after);
      end
      run_access(0, 1, 3'b011, 64'h4008, 64'h55, T + 2, 1, 64'd0, 1, 0, o);
      tests_run++;
      if (o.berr_cnt != 1 || o.stall_cyc != T + 2 || o.req_cyc != T + 1) begin
         fails++; $display("FAIL timeout_store: berr=%0d stall=%0d req=%0d required 1 %0d %0d",
                           o.berr_cnt, o.stall_cyc, o.req_cyc, T + 2, T + 1);
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      logic [63:0] wd;
      @(negedge clk);
      mem_read_in = 1; mem_write_in = 0; funct3_in = 3'b011; addr_in = 64'h40;
      bus.mem_gnt = 0; bus.mem_rvalid = 0;
      @(negedge clk);
      bus.mem_gnt = 1;
      @(negedge clk);
      bus.mem_gnt = 0; reset = 1;
      @(negedge clk);
      reset = 0; mem_read_in = 0; bus.mem_rvalid = 1; bus.mem_rdata = 64'h0123456789ABCDEF;
      #1;
      tests_run++;
      if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin
         fails++; $display("FAIL reset_mid_idle: req=%b stall=%b required 0 0", bus.mem_req, stall);
      end
      @(negedge clk);
      bus.mem_rvalid = 0;
      #1;
      tests_run++;
      if (rdata_out !== 64'd0 || bus.mem_req !== 1'b0) begin
         fails++; $display("FAIL reset_mid_late_rvalid: rdata=%h req=%b required 0 0", rdata_out, bus.mem_req);
      end
      wd = {$urandom, $urandom};
      run_access(0, 1, 3'b011, 64'h88, wd, 1, 1, 64'd0, 1, 0, o);
      tests_run++;
      if (o.stall_cyc != 3 || o.be !== 8'hFF || o.wdata !== wd || o.addr !== 64'h88 || o.berr_cnt != 0) begin
         fails++; $display("FAIL reset_mid_sd: stall=%0d be=%h wdata=%h berr=%0d required 3 FF %h 0",
                           o.stall_cyc, o.be, o.wdata, o.berr_cnt, wd);
      end
   endtask

   task automatic rand_access(input int npost, input string tag);
      obs_t o, e;
      bit rd, wr;
      logic [2:0] f3;
      logic [63:0] addr, wd, rdv;
      int kind, g, r;
      kind = $urandom_range(0, 3);
      rd = (kind != 1); wr = (kind == 1 || kind == 3);
      f3 = rd ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
      wd = {$urandom, $urandom}; rdv = {$urandom, $urandom};
      g = rd ? $urandom_range(0, T - 1) : $urandom_range(0, T + 1);
      r = $urandom_range(1, 4);
      e = model(rd, wr, f3, addr, wd, g, r, rdv);
      run_access(rd, wr, f3, addr, wd, g, r, rdv, npost, 0, o);
      tests_run++;
      if (o.stall_cyc != e.stall_cyc || o.req_cyc != e.req_cyc) begin
         fails++; $display("FAIL %s_timing: f3=%0d addr=%h stall=%0d req=%0d required %0d %0d",
                           tag, f3, addr, o.stall_cyc, o.req_cyc, e.stall_cyc, e.req_cyc);
      end
      tests_run++;
      if (o.mis_cnt != e.mis_cnt || o.berr_cnt != e.berr_cnt || !o.bubble_ok) begin
         fails++; $display("FAIL %s_errors: mis=%0d berr=%0d bubble_ok=%0d required %0d %0d 1",
                           tag, o.mis_cnt, o.berr_cnt, o.bubble_ok, e.mis_cnt, e.berr_cnt);
      end
      if (e.req_cyc > 0) begin
         tests_run++;
         if (!o.fields_ok || o.addr !== e.addr || o.be !== e.be || o.wdata !== e.wdata || o.we !== e.we) begin
            fails++; $display("FAIL %s_fields: addr=%h be=%h wdata=%h we=%b required %h %h %h %b",
                              tag, o.addr, o.be, o.wdata, o.we, e.addr, e.be, e.wdata, e.we);
         end
      end
      if (rd || e.mis_cnt != 0 || e.berr_cnt != 0) begin
         tests_run++;
         if (o.rdata !== e.rdata) begin
            fails++; $display("FAIL %s_rdata: f3=%0d off=%0d got %h required %h", tag, f3, addr[2:0], o.rdata, e.rdata);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) rand_access(1, "rand");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) rand_access(0, "b2b");
      @(negedge clk);
      mem_read_in = 0; mem_write_in = 0;
   endtask

   initial begin
      test_reset();
      test_ld();
      test_lb();
      test_sh();
      test_misalign();
      test_timeout();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
